// File: rtl/change_pkg.sv
// Shared types and default timing for the change payout path.
// Coin counts are 3 bits wide on both the controller and hopper sides.
package change_pkg;

  localparam int DEF_PULSE_LEN   = 4;
  localparam int DEF_ACK_TIMEOUT = 16;
  localparam int DEF_GAP_LEN     = 2;
  localparam int DEF_MAX_RETRY   = 2;

  typedef logic [2:0] coin_cnt_t;

  typedef enum logic [2:0] {
    IDLE,
    PULSE,
    WAIT_ACK,
    GAP,
    DONE,
    FAULT
  } disp_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/coin_dispenser_if.sv
// Controller request/status and hopper solenoid/sensor signals of the coin dispenser.
// The master side is the vending controller plus hopper; the slave side is the dispenser.
interface coin_dispenser_if;

  logic                 req;
  change_pkg::coin_cnt_t amount;
  logic                 coin_ack;
  logic                 fault_clr;
  logic                 busy;
  logic                 coin_out;
  logic                 done;
  logic                 fault;
  change_pkg::coin_cnt_t dispensed;

  modport master (
    output req, amount, coin_ack, fault_clr,
    input  busy, coin_out, done, fault, dispensed
  );

  modport slave (
    input  req, amount, coin_ack, fault_clr,
    output busy, coin_out, done, fault, dispensed
  );

endinterface

// File: rtl/coin_dispenser_ack_edge_sync.sv
// Two-flop synchronizer and rising-edge detector for the hopper drop sensor.
// Latency: evt is high 2 cycles after din rises, for one cycle; no backpressure.
module ack_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic evt
);

  // [0],[1] synchronize; [2] holds the previous synchronized level
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], din};
    end
  end

  assign evt = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/coin_dispenser.sv
// Hopper payout FSM: one solenoid pulse per coin, drop-sensor confirm, retry, latched fault.
// Latency: coin_out rises the cycle after req; no backpressure, req outside IDLE is dropped.
module coin_dispenser
  import change_pkg::*;
#(
  parameter int PULSE_LEN   = DEF_PULSE_LEN,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int GAP_LEN     = DEF_GAP_LEN,
  parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
  input logic             clk,
  input logic             rst_n,
  coin_dispenser_if.slave bus
);

  localparam int TMR_MAX = max3(PULSE_LEN, ACK_TIMEOUT, GAP_LEN);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int RTY_W   = $clog2(MAX_RETRY + 1);

  localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_LEN - 1);
  localparam logic [TMR_W-1:0] ACK_LAST   = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'(GAP_LEN - 1);
  localparam logic [RTY_W-1:0] RTY_LAST   = RTY_W'(MAX_RETRY - 1);

  disp_state_e      state;
  logic [TMR_W-1:0] timer;
  logic [RTY_W-1:0] retry;
  coin_cnt_t        remaining;
  coin_cnt_t        dispensed;
  logic             busy;
  logic             coin_out;
  logic             done;
  logic             fault;
  logic             ack_evt;

  ack_edge_sync u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus.coin_ack),
    .evt   (ack_evt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      retry     <= '0;
      remaining <= '0;
      dispensed <= '0;
      busy      <= 1'b0;
      coin_out  <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            dispensed <= '0;
            retry     <= '0;
            timer     <= '0;
            if (bus.amount != '0) begin
              remaining <= bus.amount;
              state     <= PULSE;
              coin_out  <= 1'b1;
              busy      <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        PULSE, WAIT_ACK: begin
          // A confirmed drop wins over both pulse end and timeout in the same cycle
          if (ack_evt) begin
            dispensed <= dispensed + 1'b1;
            remaining <= remaining - 1'b1;
            retry     <= '0;
            timer     <= '0;
            coin_out  <= 1'b0;
            if (remaining == coin_cnt_t'(1)) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= GAP;
            end
          end else if (state == PULSE) begin
            if (timer == PULSE_LAST) begin
              state    <= WAIT_ACK;
              timer    <= '0;
              coin_out <= 1'b0;
            end else begin
              timer <= timer + 1'b1;
            end
          end else if (timer == ACK_LAST) begin
            retry <= retry + 1'b1;
            timer <= '0;
            if (retry == RTY_LAST) begin
              state <= FAULT;
              fault <= 1'b1;
            end else begin
              state    <= PULSE;
              coin_out <= 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        GAP: begin
          if (timer == GAP_LAST) begin
            state    <= PULSE;
            timer    <= '0;
            coin_out <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        FAULT: begin
          if (bus.fault_clr) begin
            state <= IDLE;
            fault <= 1'b0;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.coin_out  = coin_out;
  assign bus.done      = done;
  assign bus.fault     = fault;
  assign bus.dispensed = dispensed;

endmodule

// File: tb/tb_coin_dispenser.sv
// Randomized bench for coin_dispenser: hopper responses are planned per attempt and the
// expected pulse lengths, end cycle, outcome and dispensed count are derived arithmetically.
module tb_coin_dispenser;

  localparam int PL = 4;
  localparam int AT = 16;
  localparam int GL = 2;
  localparam int MR = 2;

  logic clk = 1'b0;
  logic rst_n;

  coin_dispenser_if cif ();

  coin_dispenser dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (cif.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: random hopper; 1: ack 3 cycles into every pulse with a bounce;
  // 2: first coin acked, all later attempts silent; 3: first attempt silent, then acked.
  task automatic run_payout(input int amt, input int mode, input bit inject,
                            output bit exp_fault, output int exp_disp);
    int plan[16];
    bit bnc[16];
    int exp_len[$];
    int t, coin, retry, att, e, exp_end, r;
    int rel, npulse, cur, astart, busy_bad, end_rel, rk;
    bit seen_end, end_fault, prev_co, co, inj;

    for (int i = 0; i < 16; i++) begin
      bnc[i] = 1'b0;
      case (mode)
        1: begin plan[i] = 3; bnc[i] = 1'b1; end
        2: plan[i] = (i == 0) ? 3 : -1;
        3: plan[i] = (i == 0) ? -1 : 3;
        default: begin
          r = $urandom_range(0, 7);
          case (r)
            0, 1: plan[i] = -1;
            2: plan[i] = PL + AT - 3;
            3: plan[i] = 0;
            4: plan[i] = PL - 2;
            default: plan[i] = $urandom_range(0, PL + AT - 3);
          endcase
          bnc[i] = 1'($urandom_range(0, 1));
        end
      endcase
    end

    // Reference: the sensor edge is seen 2 cycles after coin_ack rises and acted on that cycle
    t = 0; coin = 0; retry = 0; att = 0; exp_fault = 1'b0;
    while (coin < amt && !exp_fault && att < 16) begin
      if (plan[att] >= 0) begin
        e = plan[att] + 2;
        exp_len.push_back((e + 1 < PL) ? e + 1 : PL);
        t += e + 1;
        coin++;
        retry = 0;
        if (coin < amt) t += GL;
      end else begin
        exp_len.push_back(PL);
        t += PL + AT;
        retry++;
        if (retry == MR) exp_fault = 1'b1;
      end
      att++;
    end
    exp_end  = t;
    exp_disp = coin;
    inj = inject && (exp_end > 8);

    cif.req    = 1'b1;
    cif.amount = 3'(amt);
    tick();
    cif.req = 1'b0;

    rel = 0; npulse = 0; cur = -1; astart = 0; busy_bad = 0;
    seen_end = 1'b0; end_fault = 1'b0; end_rel = -1; prev_co = 1'b0;
    while (!seen_end && rel < 800) begin
      co = cif.coin_out;
      if (co && !prev_co) begin
        cur++;
        astart = rel;
      end
      if (!co && prev_co) begin
        if (npulse < exp_len.size()) chk("pulse_len", rel - astart, exp_len[npulse]);
        npulse++;
      end
      prev_co = co;
      if (cif.done || cif.fault) begin
        seen_end  = 1'b1;
        end_rel   = rel;
        end_fault = cif.fault;
      end else begin
        if (!cif.busy) busy_bad++;
        rk = rel - astart;
        cif.coin_ack = (cur >= 0) && (cur < 16) && (plan[cur] >= 0) &&
                       ((rk == plan[cur]) || (bnc[cur] && rk == plan[cur] + 2));
        if (inj && rel == 5) begin
          cif.req    = 1'b1;
          cif.amount = 3'd5;
        end else begin
          cif.req = 1'b0;
        end
        tick();
        rel++;
      end
    end
    cif.coin_ack = 1'b0;
    cif.req      = 1'b0;

    chk("end_seen", seen_end, 1);
    chk("end_cycle", end_rel, exp_end);
    chk("end_is_fault", end_fault, exp_fault);
    chk("dispensed", cif.dispensed, exp_disp);
    chk("busy_at_end", cif.busy, exp_fault);
    chk("pulse_cnt", npulse, exp_len.size());
    chk("busy_during", busy_bad, 0);
    if (!exp_fault) begin
      tick();
      chk("done_width", cif.done, 0);
      chk("disp_hold", cif.dispensed, exp_disp);
    end
  endtask

  task automatic fault_clear(input int exp_disp);
    repeat (3) tick();
    chk("fault_hold", cif.fault, 1);
    chk("fault_busy", cif.busy, 1);
    chk("fault_disp", cif.dispensed, exp_disp);
    chk("fault_coin", cif.coin_out, 0);
    cif.fault_clr = 1'b1;
    tick();
    cif.fault_clr = 1'b0;
    chk("clr_fault", cif.fault, 0);
    chk("clr_busy", cif.busy, 0);
  endtask

  task automatic idle_toggle(input int exp_disp);
    for (int i = 0; i < 6; i++) begin
      cif.coin_ack = i[0];
      tick();
    end
    cif.coin_ack = 1'b0;
    repeat (4) tick();
    chk("idle_disp", cif.dispensed, exp_disp);
    chk("idle_busy", cif.busy, 0);
  endtask

  task automatic reset_mid_pulse();
    int rises, since, bad;
    bit prev;
    cif.req    = 1'b1;
    cif.amount = 3'd3;
    tick();
    cif.req = 1'b0;
    rises = 0; since = 0; prev = 1'b0;
    for (int c = 0; c < 100 && !(rises == 2 && since == 2); c++) begin
      if (cif.coin_out && !prev) begin
        rises++;
        since = 0;
      end
      prev = cif.coin_out;
      cif.coin_ack = (rises == 1 && since == 3);
      tick();
      since++;
    end
    cif.coin_ack = 1'b0;
    chk("rst_reach_coin2", rises, 2);
    chk("pre_rst_coin", cif.coin_out, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_coin_out", cif.coin_out, 0);
    chk("rst_busy", cif.busy, 0);
    chk("rst_done", cif.done, 0);
    chk("rst_fault", cif.fault, 0);
    chk("rst_disp", cif.dispensed, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (cif.coin_out || cif.busy || cif.done || cif.fault) bad++;
    end
    chk("post_rst_idle", bad, 0);
    chk("post_rst_disp", cif.dispensed, 0);
  endtask

  initial begin
    bit f;
    int d;
    int amt;
    cif.req       = 1'b0;
    cif.amount    = 3'd0;
    cif.coin_ack  = 1'b0;
    cif.fault_clr = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_busy", cif.busy, 0);
    chk("reset_coin_out", cif.coin_out, 0);
    chk("reset_done", cif.done, 0);
    chk("reset_fault", cif.fault, 0);
    chk("reset_disp", cif.dispensed, 0);
    #19 rst_n = 1'b1;
    tick();

    run_payout(3, 1, 1'b1, f, d);
    idle_toggle(d);
    run_payout(0, 1, 1'b0, f, d);
    run_payout(2, 2, 1'b0, f, d);
    fault_clear(d);
    run_payout(1, 3, 1'b0, f, d);
    idle_toggle(d);
    reset_mid_pulse();

    for (int n = 0; n < 30; n++) begin
      amt = $urandom_range(0, 7);
      run_payout(amt, 0, 1'($urandom_range(0, 1)), f, d);
      if (f) fault_clear(d);
      else if ($urandom_range(0, 1) == 1) idle_toggle(d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
